// File: rtl/e_mul_pkg.sv
// Shared types and default sizing for the execute-stage multiplier.
package e_mul_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDigit = 4;

    typedef enum logic [1:0] {
        Mul    = 2'd0,
        Mulh   = 2'd1,
        Mulhsu = 2'd2,
        Mulhu  = 2'd3
    } mul_op_t;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Calc = 2'd1,
        Fin  = 2'd2
    } state_t;

endpackage

// File: rtl/e_mul_digit.sv
// Combinational WIDTH x DIGIT partial product added onto the running upper product half.
module e_mul_digit
    import e_mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DIGIT = DefDigit
) (
    input  logic [WIDTH-1:0]       i_a,
    input  logic [DIGIT-1:0]       i_d,
    input  logic [WIDTH-1:0]       i_acc,
    output logic [WIDTH+DIGIT-1:0] o_sum
);

    localparam int unsigned PW = WIDTH + DIGIT;

    logic [PW-1:0] w_a;
    logic [PW-1:0] w_d;
    logic [PW-1:0] w_acc;

    assign w_a   = {{DIGIT{1'b0}}, i_a};
    assign w_d   = {{WIDTH{1'b0}}, i_d};
    assign w_acc = {{DIGIT{1'b0}}, i_acc};

    // (2^W-1) + (2^W-1)(2^D-1) < 2^(W+D), so the sum never overflows PW bits.
    assign o_sum = w_acc + w_a * w_d;

endmodule

// File: rtl/e_mul_unit.sv
// Iterative radix-2^DIGIT multiplier with fixed WIDTH/DIGIT+1 cycle latency.
// Define MUL_HIGH_EN to enable MULH/MULHSU/MULHU; otherwise only the unsigned low word.
module e_mul_unit
    import e_mul_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DIGIT = DefDigit
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_start,
    input  logic [1:0]       i_mul_op,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CntW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_done;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH+DIGIT-1:0] w_sum;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_word;

`ifdef MUL_HIGH_EN
    mul_op_t              r_op;
    logic                 r_neg;
    logic                 w_sgn1;
    logic                 w_sgn2;
    logic [2*WIDTH-1:0]   w_final;

    assign w_sgn1  = (mul_op_t'(i_mul_op) != Mulhu) & i_rs1[WIDTH-1];
    assign w_sgn2  = ((mul_op_t'(i_mul_op) == Mul) | (mul_op_t'(i_mul_op) == Mulh))
                     & i_rs2[WIDTH-1];
    // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
    assign w_a_mag = w_sgn1 ? -i_rs1 : i_rs1;
    assign w_b_mag = w_sgn2 ? -i_rs2 : i_rs2;
    assign w_final = r_neg ? -r_prod : r_prod;
    assign w_word  = (r_op == Mul) ? w_final[WIDTH-1:0] : w_final[2*WIDTH-1:WIDTH];
`else
    logic [1:0]           w_unused_op;

    assign w_unused_op = i_mul_op;
    assign w_a_mag     = i_rs1;
    assign w_b_mag     = i_rs2;
    assign w_word      = r_prod[WIDTH-1:0];
`endif

    e_mul_digit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_digit (
        .i_a   (r_a),
        .i_d   (r_b[DIGIT-1:0]),
        .i_acc (r_prod[2*WIDTH-1:WIDTH]),
        .o_sum (w_sum)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= Idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            Idle:    if (i_start) w_state_next = Calc;
            Calc:    if (r_cnt == CntLast) w_state_next = Fin;
            Fin:     w_state_next = Idle;
            default: w_state_next = Idle;
        endcase
        if (i_flush) w_state_next = Idle;
    end

    always_comb begin
        o_busy   = (r_state != Idle);
        o_done   = r_done;
        o_result = r_result;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
`ifdef MUL_HIGH_EN
            r_op     <= Mul;
            r_neg    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (!i_flush) begin
                unique case (r_state)
                    Idle: begin
                        if (i_start) begin
                            r_a    <= w_a_mag;
                            r_b    <= w_b_mag;
                            r_prod <= '0;
                            r_cnt  <= '0;
`ifdef MUL_HIGH_EN
                            r_op   <= mul_op_t'(i_mul_op);
                            r_neg  <= w_sgn1 ^ w_sgn2;
`endif
                        end
                    end
                    Calc: begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:DIGIT]};
                        r_b    <= r_b >> DIGIT;
                        r_cnt  <= r_cnt + CntW'(1);
                    end
                    Fin: begin
                        r_result <= w_word;
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
